// File: rtl/switch_input_unit.sv
// -----------------------------------------------------------------------------
// switch_input_unit
//
// Operator input path for the processor's IN instruction. When the processor
// raises input_flag the unit stalls it, lights waiting_led, and waits for the
// operator to set the switches and press the confirm key. On a debounced
// press it captures the synchronised switch value into data_out (optionally
// sign-applied from SW[17]) and pulses data_valid for one cycle.
//
// Ports:
//   clk          system clock, all state on posedge
//   reset        asynchronous active-low reset
//   halt         processor halted; aborts any pending request
//   input_flag   processor request for an input word
//   SW[17:0]     raw board switches (asynchronous)
//   KEY          raw confirm key, active-low, asynchronous and bouncy
//   data_out     captured input word, held until the next capture
//   data_valid   one-cycle pulse, data_out is new this cycle
//   stall        processor must hold the PC while high
//   waiting_led  high while waiting for the operator
//
// Parameters:
//   DEBOUNCE_CYCLES  cycles a new key level must persist before acceptance (>= 2)
//   DATA_BITS        number of SW bits used as magnitude (1..17)
//   SIGN_EN          1: SW[17] negates the captured value; 0: SW[17] ignored
//
// state      | meaning
// -----------+---------------------------------------------------------------
// S_IDLE     | no request in progress
// S_ARM      | request seen with key already held; waiting for release
// S_WAIT_PRS | waiting for a fresh debounced press
// S_DONE     | capture made; data_valid high for this single cycle
// -----------------------------------------------------------------------------
module switch_input_unit #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int DATA_BITS       = 17,
    parameter int SIGN_EN         = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        halt,
    input  logic        input_flag,
    input  logic [17:0] SW,
    input  logic        KEY,
    output logic [31:0] data_out,
    output logic        data_valid,
    output logic        stall,
    output logic        waiting_led
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ARM      = 2'd1,
        S_WAIT_PRS = 2'd2,
        S_DONE     = 2'd3
    } state_t;

    state_t state, state_nxt;

    // ------------------------------------------------------------------
    // Two-flop synchronisers. KEY idles high (released), so its flops
    // reset to 1 to avoid a phantom press coming out of reset.
    // ------------------------------------------------------------------
    logic [17:0] sw_meta, sw_sync;
    logic        key_meta, key_sync;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sw_meta  <= '0;
            sw_sync  <= '0;
            key_meta <= 1'b1;
            key_sync <= 1'b1;
        end else begin
            sw_meta  <= SW;
            sw_sync  <= sw_meta;
            key_meta <= KEY;
            key_sync <= key_meta;
        end
    end

    // ------------------------------------------------------------------
    // Debounce: the counter runs only while the synchronised key disagrees
    // with the accepted level; any agreement restarts the qualification.
    // press_evt is registered so it is high in the cycle immediately after
    // stable_key goes to pressed.
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] db_cnt;
    logic             stable_key;
    logic             press_evt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            db_cnt     <= '0;
            stable_key <= 1'b1;
            press_evt  <= 1'b0;
        end else begin
            press_evt <= 1'b0;
            if (key_sync == stable_key) begin
                db_cnt <= '0;
            end else if (db_cnt == CNT_MAX) begin
                stable_key <= key_sync;
                db_cnt     <= '0;
                press_evt  <= ~key_sync;
            end else begin
                db_cnt <= db_cnt + CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Value formation from the synchronised switches. Two's complement of
    // a zero magnitude is zero, so a "negative zero" naturally yields 0.
    // ------------------------------------------------------------------
    logic [31:0] mag;
    logic [31:0] val;
    logic        neg;

    always_comb begin
        mag = 32'(sw_sync[DATA_BITS-1:0]);
        neg = (SIGN_EN != 0) && sw_sync[17];
        val = neg ? (~mag + 32'd1) : mag;
    end

    // ------------------------------------------------------------------
    // Request FSM
    // ------------------------------------------------------------------
    logic req_ok;
    logic capture;

    assign req_ok = input_flag & ~halt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        unique case (state)
            S_IDLE: begin
                // A key already held at request time must be released first.
                if (req_ok) begin
                    state_nxt = stable_key ? S_WAIT_PRS : S_ARM;
                end
            end
            S_ARM: begin
                if (!req_ok) begin
                    state_nxt = S_IDLE;
                end else if (stable_key) begin
                    state_nxt = S_WAIT_PRS;
                end
            end
            S_WAIT_PRS: begin
                // Abort takes priority over a coincident press.
                if (!req_ok) begin
                    state_nxt = S_IDLE;
                end else if (press_evt) begin
                    capture   = 1'b1;
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_out <= '0;
        end else if (capture) begin
            data_out <= val;
        end
    end

    // Outputs decoded from state so reset clears them without a clock edge.
    // stall is combinational on input_flag so the processor is held in the
    // very cycle the request appears, and it drops in DONE so the processor
    // can consume data_out in that cycle.
    assign data_valid  = (state == S_DONE);
    assign stall       = req_ok & (state != S_DONE);
    assign waiting_led = (state == S_ARM) | (state == S_WAIT_PRS);

endmodule

// File: tb/tb_switch_input_unit.sv
module tb_switch_input_unit;

    logic        clk;
    logic        reset;
    logic        halt;
    logic        input_flag;
    logic [17:0] SW;
    logic        KEY;
    logic [31:0] data_out;
    logic        data_valid;
    logic        stall;
    logic        waiting_led;

    int n_checks = 0;
    int n_fails  = 0;

    switch_input_unit #(
        .DEBOUNCE_CYCLES(4),
        .DATA_BITS      (17),
        .SIGN_EN        (1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .halt       (halt),
        .input_flag (input_flag),
        .SW         (SW),
        .KEY        (KEY),
        .data_out   (data_out),
        .data_valid (data_valid),
        .stall      (stall),
        .waiting_led(waiting_led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for the data_valid pulse after KEY has been driven low,
    // then checks latency, captured data, stall in DONE and pulse width.
    task automatic wait_capture(input string tag, input logic [31:0] exp_data, input bit drop_flag);
        int n;
        n = 0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (data_valid === 1'b1) begin
                n = i;
                break;
            end
        end
        check({tag, " latency"}, 32'(n), 32'd7);
        check({tag, " data"}, data_out, exp_data);
        check({tag, " stall in done"}, {31'd0, stall}, 32'd0);
        if (drop_flag) input_flag = 1'b0;
        tick();
        check({tag, " single pulse"}, {31'd0, data_valid}, 32'd0);
    endtask

    task automatic release_key();
        KEY = 1'b1;
        repeat (8) tick();
    endtask

    task automatic count_pulses(input string tag, input int cycles);
        int p;
        p = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (data_valid === 1'b1) p++;
        end
        check(tag, 32'(p), 32'd0);
    endtask

    initial begin
        reset      = 1'b0;
        halt       = 1'b0;
        input_flag = 1'b0;
        SW         = '0;
        KEY        = 1'b1;

        // Reset state
        repeat (2) tick();
        check("reset data_out", data_out, 32'd0);
        check("reset data_valid", {31'd0, data_valid}, 32'd0);
        check("reset waiting_led", {31'd0, waiting_led}, 32'd0);
        reset = 1'b1;
        repeat (3) tick();
        check("idle stall", {31'd0, stall}, 32'd0);

        // 1. Basic capture
        SW = 18'd1234;
        repeat (3) tick();
        input_flag = 1'b1;
        #1;
        check("t1 stall same cycle", {31'd0, stall}, 32'd1);
        tick();
        check("t1 waiting_led", {31'd0, waiting_led}, 32'd1);
        KEY = 1'b0;
        wait_capture("t1", 32'd1234, 1'b1);
        release_key();

        // 2. Negative value, then negative zero
        SW = {1'b1, 17'd5};
        repeat (3) tick();
        input_flag = 1'b1;
        tick();
        KEY = 1'b0;
        wait_capture("t2 neg", 32'hFFFF_FFFB, 1'b1);
        release_key();
        SW = 18'h20000;
        repeat (3) tick();
        input_flag = 1'b1;
        tick();
        KEY = 1'b0;
        wait_capture("t2 negzero", 32'd0, 1'b1);
        release_key();

        // 3. Bounce rejection
        SW = 18'd77;
        repeat (3) tick();
        input_flag = 1'b1;
        tick();
        begin
            int early;
            early = 0;
            for (int i = 0; i < 10; i++) begin
                KEY = ~KEY;
                repeat (2) begin
                    tick();
                    if (data_valid === 1'b1) early++;
                end
            end
            check("t3 no pulse while bouncing", 32'(early), 32'd0);
        end
        KEY = 1'b0;
        wait_capture("t3", 32'd77, 1'b1);
        count_pulses("t3 no extra pulse", 8);
        release_key();

        // 4. Key held at request, then back-to-back requests
        KEY = 1'b0;
        repeat (8) tick();
        SW = 18'd4321;
        input_flag = 1'b1;
        tick();
        check("t4 arm waiting_led", {31'd0, waiting_led}, 32'd1);
        check("t4 arm stall", {31'd0, stall}, 32'd1);
        count_pulses("t4 no stale accept", 10);
        check("t4 data held", data_out, 32'd77);
        KEY = 1'b1;
        repeat (8) tick();
        KEY = 1'b0;
        wait_capture("t4 first", 32'd4321, 1'b0);
        SW = 18'd99;
        tick();
        check("t4 b2b waiting_led", {31'd0, waiting_led}, 32'd1);
        count_pulses("t4 b2b needs new press", 10);
        check("t4 b2b data held", data_out, 32'd4321);
        KEY = 1'b1;
        repeat (8) tick();
        KEY = 1'b0;
        wait_capture("t4 second", 32'd99, 1'b1);
        release_key();

        // 5a. Abort by halt
        SW = 18'd555;
        repeat (3) tick();
        input_flag = 1'b1;
        tick();
        check("t5a waiting", {31'd0, waiting_led}, 32'd1);
        halt = 1'b1;
        #1;
        check("t5a stall on halt", {31'd0, stall}, 32'd0);
        tick();
        check("t5a waiting_led off", {31'd0, waiting_led}, 32'd0);
        KEY = 1'b0;
        count_pulses("t5a no valid", 10);
        check("t5a data unchanged", data_out, 32'd99);
        input_flag = 1'b0;
        tick();
        halt = 1'b0;
        release_key();

        // 5b. Abort by dropping input_flag
        input_flag = 1'b1;
        tick();
        check("t5b waiting", {31'd0, waiting_led}, 32'd1);
        input_flag = 1'b0;
        tick();
        check("t5b waiting_led off", {31'd0, waiting_led}, 32'd0);
        KEY = 1'b0;
        count_pulses("t5b no valid", 10);
        check("t5b data unchanged", data_out, 32'd99);
        release_key();

        // 6. Async reset mid-wait with data_out=1234
        SW = 18'd1234;
        repeat (3) tick();
        input_flag = 1'b1;
        tick();
        KEY = 1'b0;
        wait_capture("t6 setup", 32'd1234, 1'b1);
        release_key();
        input_flag = 1'b1;
        tick();
        check("t6 pre waiting", {31'd0, waiting_led}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("t6 async data_out", data_out, 32'd0);
        check("t6 async data_valid", {31'd0, data_valid}, 32'd0);
        check("t6 async waiting_led", {31'd0, waiting_led}, 32'd0);
        check("t6 stall follows flag", {31'd0, stall}, 32'd1);
        input_flag = 1'b0;
        tick();
        reset = 1'b1;
        repeat (2) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
